// File: rtl/db_scan_ctrl_if.sv
// Switch-side and user-side signal bundle of the debounce scheduler.
// slave: the scheduler itself; master: whoever drives switches and consumes levels.
interface db_scan_ctrl_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] sw_i;       // raw asynchronous switch levels
    logic [NCH-1:0] en_i;       // per-channel enable, 0 freezes the channel
    logic [NCH-1:0] db_o;       // debounced levels
    logic [NCH-1:0] press_o;    // one-cycle pulse on db 0->1
    logic [NCH-1:0] release_o;  // one-cycle pulse on db 1->0
    logic           m_tick_o;   // one-cycle prescaler tick

    modport master (
        output sw_i,
        output en_i,
        input  db_o,
        input  press_o,
        input  release_o,
        input  m_tick_o
    );

    modport slave (
        input  sw_i,
        input  en_i,
        output db_o,
        output press_o,
        output release_o,
        output m_tick_o
    );
endinterface

// File: rtl/db_scan_ctrl.sv
// Multi-channel debounce scheduler: one shared tick prescaler and one evaluation
// slot visited round-robin, replacing a private counter/FSM per switch.
module db_scan_ctrl #(
    parameter int NCH   = 4,
    parameter int N     = 19,
    parameter int NSAMP = 3
) (
    input  logic          clk,
    input  logic          reset,
    db_scan_ctrl_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(NSAMP + 1);

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [N-1:0]   presc_q, presc_d;
    logic           tick_q, tick_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] db_q, db_d;
    logic [NCH-1:0] press_q, press_d;
    logic [NCH-1:0] rel_q, rel_d;

    always_comb begin
        presc_d = presc_q + 1'b1;
        tick_d  = (presc_q == '1);
        ptr_d   = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = '0;
        rel_d   = '0;
        pend_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            // A tick landing on the very cycle a channel is visited survives to its next visit.
            pend_d[i] = (pend_q[i] & (ptr_q != PW'(i))) | tick_q;
            if (ptr_q == PW'(i)) begin
                if (!bus.en_i[i]) begin
                    cnt_d[i] = '0;
                end else if (sync2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (pend_q[i]) begin
                    if (cnt_q[i] == CW'(NSAMP - 1)) begin
                        db_d[i]    = ~db_q[i];
                        cnt_d[i]   = '0;
                        press_d[i] = ~db_q[i];
                        rel_d[i]   = db_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            ptr_q   <= '0;
            pend_q  <= '0;
            db_q    <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.sw_i;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.db_o      = db_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = rel_q;
    assign bus.m_tick_o  = tick_q;
endmodule
